// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a simple request bus into APB SETUP/ACCESS phases
// for two slaves. The top address bit selects the slave. A wait-state timeout
// aborts an ACCESS phase that stalls too long. Every APB-facing output and
// every status output comes straight from a flop.
module apb_master_bridge #(
  parameter int AW       = 9,
  parameter int DW       = 8,
  parameter int WAIT_MAX = 16
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          transfer,
  input  logic          READ_WRITE,
  input  logic [AW-1:0] apb_read_paddr,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [DW-1:0] apb_write_data,
  output logic [DW-1:0] apb_read_data_out,
  output logic          xfer_done,
  output logic          slverr_out,
  output logic          psel1,
  output logic          psel2,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic          pready,
  input  logic [DW-1:0] prdata,
  input  logic          pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // The counter only needs to reach WAIT_MAX-1, the last waiting cycle.
  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

  state_t        state_q, state_d;
  logic          psel1_q, psel1_d;
  logic          psel2_q, psel2_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          xfer_done_q, xfer_done_d;
  logic          slverr_q, slverr_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic [AW-1:0] req_addr;
  logic          take_req;

  // The request address is chosen by direction before it is captured.
  assign req_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;

  // Next-state and next-output logic for the IDLE/SETUP/ACCESS master.
  always_comb begin
    state_d     = state_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rdata_d     = rdata_q;
    wait_cnt_d  = wait_cnt_q;
    xfer_done_d = 1'b0;
    slverr_d    = 1'b0;
    take_req    = 1'b0;

    unique case (state_q)
      IDLE: begin
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
        take_req  = transfer;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          xfer_done_d = 1'b1;
          slverr_d    = pslverr;
          // Read data is returned even when the slave flags an error.
          if (!pwrite_q) begin
            rdata_d = prdata;
          end
          state_d   = IDLE;
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
          take_req  = transfer;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Stalled slave: end the transfer with an error and no data update.
          xfer_done_d = 1'b1;
          slverr_d    = 1'b1;
          state_d     = IDLE;
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    // A new request is captured from IDLE or from a completing ACCESS cycle.
    // The latter gives a back-to-back SETUP with no IDLE gap.
    if (take_req) begin
      state_d    = SETUP;
      pwrite_d   = !READ_WRITE;
      paddr_d    = req_addr;
      psel1_d    = !req_addr[AW-1];
      psel2_d    = req_addr[AW-1];
      penable_d  = 1'b0;
      wait_cnt_d = '0;
      if (!READ_WRITE) begin
        pwdata_d = apb_write_data;
      end
    end
  end

  // State and output registers. Reset clears everything and drops any transfer in flight.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rdata_q     <= '0;
      wait_cnt_q  <= '0;
      xfer_done_q <= 1'b0;
      slverr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rdata_q     <= rdata_d;
      wait_cnt_q  <= wait_cnt_d;
      xfer_done_q <= xfer_done_d;
      slverr_q    <= slverr_d;
    end
  end

  assign psel1             = psel1_q;
  assign psel2             = psel2_q;
  assign penable           = penable_q;
  assign pwrite            = pwrite_q;
  assign paddr             = paddr_q;
  assign pwdata            = pwdata_q;
  assign apb_read_data_out = rdata_q;
  assign xfer_done         = xfer_done_q;
  assign slverr_out        = slverr_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge. Transactions come from a directed list and
// then a random list. A transaction-level model predicts what the bridge
// should drive, and the bench acts as the APB slave.
module tb_apb_master_bridge;

  localparam int AW       = 9;
  localparam int DW       = 8;
  localparam int WAIT_MAX = 16;
  localparam int NEVER    = 1000;  // pready delay that forces a timeout

  logic          pclk = 1'b0;
  logic          preset;
  logic          transfer;
  logic          READ_WRITE;
  logic [AW-1:0] apb_read_paddr;
  logic [AW-1:0] apb_write_paddr;
  logic [DW-1:0] apb_write_data;
  logic [DW-1:0] apb_read_data_out;
  logic          xfer_done;
  logic          slverr_out;
  logic          psel1;
  logic          psel2;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  apb_master_bridge #(.AW(AW), .DW(DW), .WAIT_MAX(WAIT_MAX)) dut (
    .pclk              (pclk),
    .preset            (preset),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_read_paddr    (apb_read_paddr),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_data_out (apb_read_data_out),
    .xfer_done         (xfer_done),
    .slverr_out        (slverr_out),
    .psel1             (psel1),
    .psel2             (psel2),
    .penable           (penable),
    .pwrite            (pwrite),
    .paddr             (paddr),
    .pwdata            (pwdata),
    .pready            (pready),
    .prdata            (prdata),
    .pslverr           (pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rdat;
    int            delay;  // ACCESS cycles with pready low before pready high
    logic          err;
    logic          b2b;    // chain the next request into this completion
  } txn_t;

  int errors = 0;
  int checks = 0;

  // Model state: what the bridge should currently expose.
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_wdata;

  txn_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample at the falling edge. Check the select invariants each cycle.
  task automatic step();
    @(posedge pclk);
    @(negedge pclk);
    check("sel_mutex", 32'(psel1 & psel2), 32'd0);
    check("pen_no_sel", 32'(penable & ~(psel1 | psel2)), 32'd0);
  endtask

  task automatic present(input txn_t t);
    transfer   = 1'b1;
    READ_WRITE = t.rd;
    if (t.rd) begin
      apb_read_paddr  = t.addr;
      apb_write_paddr = AW'($urandom);
      apb_write_data  = DW'($urandom);
    end else begin
      apb_write_paddr = t.addr;
      apb_read_paddr  = AW'($urandom);
      apb_write_data  = t.wd;
    end
  endtask

  function automatic txn_t mk(input logic rd, input int addr, input int wd, input int rdat,
                              input int delay, input logic err, input logic b2b);
    txn_t t;
    t.rd    = rd;
    t.addr  = AW'(addr);
    t.wd    = DW'(wd);
    t.rdat  = DW'(rdat);
    t.delay = delay;
    t.err   = err;
    t.b2b   = b2b;
    return t;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_psel1"}, 32'(psel1), 32'd0);
    check({tag, "_psel2"}, 32'(psel2), 32'd0);
    check({tag, "_penable"}, 32'(penable), 32'd0);
  endtask

  // Run every queued transaction through the bridge against the model.
  task automatic run_queue();
    logic chained = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      txn_t          t = q[i];
      logic          timeout = (t.delay >= WAIT_MAX);
      logic          nxt_chain = t.b2b && !timeout && (i + 1 < q.size());
      logic          exp_slverr;
      logic [DW-1:0] exp_wd;
      int            acc_cycles = 0;
      if (!chained) begin
        present(t);
        step();
      end
      transfer = 1'b0;
      exp_wd   = t.rd ? m_wdata : t.wd;
      m_wdata  = exp_wd;
      // SETUP phase
      check("setup_psel1", 32'(psel1), 32'(!t.addr[AW-1]));
      check("setup_psel2", 32'(psel2), 32'(t.addr[AW-1]));
      check("setup_penable", 32'(penable), 32'd0);
      check("setup_paddr", 32'(paddr), 32'(t.addr));
      check("setup_pwrite", 32'(pwrite), 32'(!t.rd));
      check("setup_pwdata", 32'(pwdata), 32'(exp_wd));
      step();
      // ACCESS phase(s)
      for (int k = 0; k < WAIT_MAX; k++) begin
        logic rdy = (k == t.delay);
        check("acc_penable", 32'(penable), 32'd1);
        check("acc_psel1", 32'(psel1), 32'(!t.addr[AW-1]));
        check("acc_psel2", 32'(psel2), 32'(t.addr[AW-1]));
        check("acc_paddr", 32'(paddr), 32'(t.addr));
        check("acc_pwrite", 32'(pwrite), 32'(!t.rd));
        check("acc_pwdata", 32'(pwdata), 32'(exp_wd));
        check("acc_no_done", 32'(xfer_done), 32'd0);
        pready  = rdy;
        prdata  = rdy ? t.rdat : DW'($urandom);
        pslverr = rdy ? t.err : 1'($urandom);
        if (rdy && nxt_chain) present(q[i + 1]);
        acc_cycles++;
        step();
        if (rdy) break;
      end
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = DW'($urandom);
      exp_slverr = timeout ? 1'b1 : t.err;
      if (t.rd && !timeout) m_rdata = t.rdat;
      check("done_pulse", 32'(xfer_done), 32'd1);
      check("done_slverr", 32'(slverr_out), 32'(exp_slverr));
      check("done_rdata", 32'(apb_read_data_out), 32'(m_rdata));
      $display("txn %0d: %s addr=%h wd=%h delay=%0d err=%0b b2b=%0b acc=%0d slverr=%0b rdata=%h",
               i, t.rd ? "RD" : "WR", t.addr, t.wd, t.delay, t.err, nxt_chain, acc_cycles,
               slverr_out, apb_read_data_out);
      if (!nxt_chain) begin
        check_idle_outputs("post");
        for (int g = 0; g < int'($urandom_range(1, 0)); g++) begin
          step();
          check("gap_no_done", 32'(xfer_done), 32'd0);
          check_idle_outputs("gap");
        end
      end
      chained = nxt_chain;
    end
    q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel1"}, 32'(psel1), 32'd0);
    check({tag, "_psel2"}, 32'(psel2), 32'd0);
    check({tag, "_penable"}, 32'(penable), 32'd0);
    check({tag, "_pwrite"}, 32'(pwrite), 32'd0);
    check({tag, "_paddr"}, 32'(paddr), 32'd0);
    check({tag, "_pwdata"}, 32'(pwdata), 32'd0);
    check({tag, "_rdata"}, 32'(apb_read_data_out), 32'd0);
    check({tag, "_done"}, 32'(xfer_done), 32'd0);
    check({tag, "_slverr"}, 32'(slverr_out), 32'd0);
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) begin
      int dly = ($urandom_range(7, 0) == 0) ? NEVER : int'($urandom_range(3, 0));
      q.push_back(mk(1'($urandom), int'($urandom), int'($urandom), int'($urandom), dly,
                     ($urandom_range(3, 0) == 0), ($urandom_range(2, 0) == 0)));
    end
  endtask

  initial begin
    txn_t t;
    preset          = 1'b1;
    transfer        = 1'b0;
    READ_WRITE      = 1'b0;
    apb_read_paddr  = '0;
    apb_write_paddr = '0;
    apb_write_data  = '0;
    pready          = 1'b0;
    prdata          = '0;
    pslverr         = 1'b0;
    m_rdata         = '0;
    m_wdata         = '0;
    step();
    step();
    check_all_zero("reset");
    preset = 1'b0;
    step();
    check_all_zero("idle");

    // Directed cases: simple write, delayed read, back-to-back pair, timeout, slave error.
    q.push_back(mk(1'b0, 'h0A5, 'h3C, 'h00, 0, 1'b0, 1'b0));
    q.push_back(mk(1'b1, 'h1F0, 'h00, 'h77, 3, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 'h010, 'h5A, 'h00, 0, 1'b0, 1'b1));
    q.push_back(mk(1'b1, 'h110, 'h00, 'hC3, 0, 1'b0, 1'b0));
    q.push_back(mk(1'b1, 'h020, 'h00, 'hEE, NEVER, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 'h033, 'h99, 'h00, 0, 1'b1, 1'b0));
    q.push_back(mk(1'b1, 'h133, 'h00, 'h4B, 1, 1'b1, 1'b0));
    run_queue();

    add_random(30);
    run_queue();

    // Reset in the middle of ACCESS drops the transfer.
    t = mk(1'b0, 'h1AB, 'hD2, 'h00, NEVER, 1'b0, 1'b0);
    present(t);
    step();
    transfer = 1'b0;
    step();
    check("pre_rst_penable", 32'(penable), 32'd1);
    preset = 1'b1;
    step();
    preset = 1'b0;
    check_all_zero("midrst");
    m_rdata = '0;
    m_wdata = '0;
    step();
    check("post_rst_no_done", 32'(xfer_done), 32'd0);
    check_idle_outputs("post_rst");
    $display("txn reset-abort: WR addr=%h aborted by preset", t.addr);

    add_random(20);
    run_queue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts the testbench/user-side request bus (transfer, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data) into APB protocol phases for two slaves.
- Returns read data on apb_read_data_out.
- Sits between the request interface and the two APB slave blocks.
- Implements the IDLE/SETUP/ACCESS master FSM, address-based slave decode, and a wait-state timeout.

Parameters:
AW, 9, address width; paddr[AW-1] selects the slave (0 = slave 1, 1 = slave 2)
DW, 8, data width
WAIT_MAX, 16, max consecutive ACCESS cycles with pready low before abort (>=1)

Ports:
pclk  input  1  clock; all logic on rising edge
preset  input  1  synchronous, active-high reset
transfer  input  1  request valid
READ_WRITE  input  1  1 = read, 0 = write
apb_read_paddr  input  AW  read address
apb_write_paddr  input  AW  write address
apb_write_data  input  DW  write data
apb_read_data_out  output  DW  last completed read data
xfer_done  output  1  one-cycle pulse at transfer completion (normal or abort)
slverr_out  output  1  one-cycle pulse with xfer_done when the slave errored or timed out
psel1  output  1  APB select, slave 1
psel2  output  1  APB select, slave 2
penable  output  1  APB enable
pwrite  output  1  APB direction (1 = write)
paddr  output  AW  APB address
pwdata  output  DW  APB write data
pready  input  1  OR of the slave ready signals (muxed by select)
prdata  input  DW  selected slave read data
pslverr  input  1  selected slave error

Behaviour:
- Reset (preset high at an edge) forces state IDLE and all outputs to 0, including apb_read_data_out, paddr, pwdata and the wait counter.
  - Reset asserted mid-transfer aborts the transfer immediately: no xfer_done, no data update.
- All APB outputs are registered.
- IDLE:
  - psel1/psel2/penable = 0.
  - If transfer = 1 at an edge:
    - Capture direction (pwrite = !READ_WRITE).
    - Capture the address: apb_read_paddr if READ_WRITE = 1, else apb_write_paddr.
    - Capture pwdata = apb_write_data on writes; pwdata is held on reads.
    - Go to SETUP.
  - Otherwise stay in IDLE; paddr/pwdata/pwrite hold their last values.
- SETUP:
  - Exactly one of psel1/psel2 is high, decoded from captured paddr[AW-1]; penable = 0.
  - Always go to ACCESS on the next edge.
- ACCESS:
  - Select held, penable = 1; paddr/pwrite/pwdata are stable for the whole SETUP+ACCESS window.
  - If pready = 1:
    - Complete the transfer: xfer_done = 1 next cycle.
    - slverr_out = pslverr.
    - On a read, apb_read_data_out <= prdata, even if pslverr = 1.
    - Then, if transfer = 1 in the same cycle, capture the new request and go directly to SETUP (back-to-back; penable drops, select re-decoded). Otherwise go to IDLE.
  - If pready = 0: increment the wait counter.
    - When the counter reaches WAIT_MAX - 1 with pready still low, abort.
    - Abort means: xfer_done = 1, slverr_out = 1, apb_read_data_out unchanged, go to IDLE.
  - The wait counter clears on entry to SETUP.
- transfer is sampled only in IDLE and in a completing ACCESS cycle. It is ignored in SETUP and in waiting ACCESS cycles. Upstream must hold the request until xfer_done.
- Minimum latency, request sampled at edge N:
  - SETUP visible after N.
  - ACCESS after N+1.
  - Completion at edge N+2 with pready = 1.
  - xfer_done high during cycle N+3.
- psel1 and psel2 are never high simultaneously.
- penable is never high without a select.

Test Plan:
- Write 0x0A5 (slave 1), data 0x3C, pready = 1 on first ACCESS -> psel1 high for 2 cycles, penable in cycle 2 only, paddr = 0x0A5, pwdata = 0x3C, pwrite = 1, xfer_done pulse, slverr_out = 0.
- Read 0x1F0 (slave 2), prdata = 0x77, pready delayed 3 cycles -> psel2 held through SETUP+4 ACCESS cycles, paddr stable, apb_read_data_out = 0x77 after completion.
- Back-to-back: write 0x010, then read 0x110 with transfer held -> direct ACCESS->SETUP, select switches psel1->psel2, no IDLE cycle, two xfer_done pulses.
- Timeout: read 0x020, pready held low -> abort after WAIT_MAX = 16 ACCESS cycles, xfer_done and slverr_out pulse together, apb_read_data_out unchanged, state IDLE.
- Slave error: write with pslverr = 1 and pready = 1 -> slverr_out pulse coincident with xfer_done.
- preset asserted in ACCESS -> next cycle all outputs 0, no xfer_done; a subsequent transfer proceeds normally.
